// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings, FSM state type and op classification for alu_seq
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [3:0] ALU_SLTU   = 4'b1010;
  localparam logic [3:0] ALU_MUL    = 4'b1100;
  localparam logic [3:0] ALU_MULHU  = 4'b1101;
  localparam logic [3:0] ALU_DIVU   = 4'b1110;
  localparam logic [3:0] ALU_REMU   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // The whole 11xx quadrant is the iterative mul/div group.
  function automatic logic is_multi_cycle(input logic [3:0] sel);
    return sel[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative unsigned shift-add multiply / restoring divide
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;

  // Multiplier sits in the low half of acc and is consumed LSB first.
  assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
  assign acc_nxt = {sum, acc[XLEN-1:1]};

  assign shifted = {rem, quo[XLEN-1]};
  assign ge      = shifted >= {1'b0, b_q};
  assign rem_nxt = ge ? XLEN'(shifted - {1'b0, b_q}) : shifted[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ge};

  // Final step's value is handed over combinationally so the top registers it on the same edge.
  assign done = (cnt == CNT_W'(1));

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = acc_nxt[XLEN-1:0];
      2'b01:   result = acc_nxt[2*XLEN-1:XLEN];
      2'b10:   result = quo_nxt;
      default: result = rem_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= '0;
      b_q  <= '0;
      acc  <= '0;
      rem  <= '0;
      quo  <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt  <= CNT_W'(XLEN);
      op_q <= op;
      b_q  <= b;
      acc  <= {{XLEN{1'b0}}, a};
      rem  <= '0;
      quo  <= a;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (op_q[1]) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
      end else begin
        acc <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered EX-stage ALU with valid/ready; mul/div under ALU_SEQ_MULDIV_EN
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  input  logic [3:0]      aluSel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            illegal
);

  localparam int SH_W = $clog2(XLEN);

  alu_state_t      state;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  logic            accept;
  logic            go_busy;
  logic            sc_illegal;
  logic [XLEN-1:0] sc_result;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign illegal   = illegal_q;

`ifdef ALU_SEQ_MULDIV_EN
  logic            div_by_zero;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign div_by_zero = ((aluSel == ALU_DIVU) || (aluSel == ALU_REMU)) && (i_2 == '0);
  assign go_busy     = is_multi_cycle(aluSel) && !div_by_zero;

  alu_muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (flush),
    .start  (accept && go_busy),
    .op     (aluSel[1:0]),
    .a      (i_1),
    .b      (i_2),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign go_busy = 1'b0;
`endif

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (aluSel)
      ALU_AND:    sc_result = i_1 & i_2;
      ALU_OR:     sc_result = i_1 | i_2;
      ALU_ADD:    sc_result = i_1 + i_2;
      ALU_XOR:    sc_result = i_1 ^ i_2;
      ALU_SUB:    sc_result = i_1 - i_2;
      ALU_SLL:    sc_result = i_1 << i_2[SH_W-1:0];
      ALU_SRL:    sc_result = i_1 >> i_2[SH_W-1:0];
      ALU_SRA:    sc_result = $signed(i_1) >>> i_2[SH_W-1:0];
      ALU_SLT:    sc_result = {{(XLEN-1){1'b0}}, $signed(i_1) < $signed(i_2)};
      ALU_PASS_B: sc_result = i_2;
      ALU_SLTU:   sc_result = {{(XLEN-1){1'b0}}, i_1 < i_2};
`ifdef ALU_SEQ_MULDIV_EN
      // Only reached as single-cycle ops when the divisor is zero.
      ALU_DIVU:   sc_result = '1;
      ALU_REMU:   sc_result = i_1;
      ALU_MUL,
      ALU_MULHU:  sc_result = '0;
`endif
      default:    sc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      if (go_busy) begin
        state <= BUSY;
      end else begin
        state     <= DONE;
        result_q  <= sc_result;
        zero_q    <= (sc_result == '0);
        illegal_q <= sc_illegal;
      end
    end else begin
      case (state)
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            result_q  <= md_result;
            zero_q    <= (md_result == '0);
            illegal_q <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] i_1 = '0;
  logic [XLEN-1:0] i_2 = '0;
  logic [3:0]      aluSel = '0;
  logic            in_ready, out_valid, zero_flag, illegal;
  logic [XLEN-1:0] result;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_1       (i_1),
    .i_2       (i_2),
    .aluSel    (aluSel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_flag (zero_flag),
    .illegal   (illegal)
  );

  // Returns {illegal, result} straight from the instruction-set definition.
  function automatic logic [XLEN:0] model(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0]   r;
    logic              ill;
    logic [2*XLEN-1:0] p;
    int                sh;
    r   = '0;
    ill = 1'b0;
    sh  = int'(b % XLEN);
    p   = (2*XLEN)'(a) * (2*XLEN)'(b);
    case (sel)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a - b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = $signed(a) >>> sh;
      4'd8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:  r = b;
      4'd10: r = (a < b) ? 1 : 0;
      4'd12: r = p[XLEN-1:0];
      4'd13: r = p[2*XLEN-1:XLEN];
      4'd14: r = (b == 0) ? '1 : a / b;
      4'd15: r = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
    if (!MD_EN && sel >= 4'd12) begin
      r   = '0;
      ill = 1'b1;
    end
    return {ill, r};
  endfunction

  function automatic int model_lat(input logic [3:0] sel, input logic [XLEN-1:0] b);
    if (MD_EN && sel >= 4'd12 && !(sel >= 4'd14 && b == 0)) return XLEN + 1;
    return 1;
  endfunction

  // Present one op from IDLE, scramble the bus while it runs, and return cycles until out_valid.
  task automatic issue(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int lat);
    aluSel = sel; i_1 = a; i_2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      aluSel = 4'($urandom); i_1 = $urandom; i_2 = $urandom;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (result !== '0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
    total++; if (zero_flag !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero_flag); else pass_cnt++;
    total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    int lat;
    issue(4'd2, 32'hFFFF_FFFF, 32'h1, lat);
    total++; if (lat !== 1) $display("FAIL add_wrap_latency got %0d exp 1", lat); else pass_cnt++;
    total++; if (result !== '0) $display("FAIL add_wrap_result got %h exp 0", result); else pass_cnt++;
    total++; if (zero_flag !== 1'b1) $display("FAIL add_wrap_zero got %b exp 1", zero_flag); else pass_cnt++;
    consume();
  endtask

  task automatic test_sra_hold();
    int lat;
    issue(4'd7, 32'h8000_0000, 32'h1F, lat);
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL sra_hold_valid cyc %0d got %b exp 1", k, out_valid); else pass_cnt++;
      total++; if (result !== 32'hFFFF_FFFF) $display("FAIL sra_hold_result cyc %0d got %h exp ffffffff", k, result); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL sra_hold_in_ready cyc %0d got %b exp 0", k, in_ready); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL sra_release_in_ready got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_muldiv_directed();
    logic [3:0]      sel_t [6];
    logic [XLEN-1:0] a_t   [6];
    logic [XLEN-1:0] b_t   [6];
    logic [XLEN-1:0] exp_t [6];
    int              lat_t [6];
    logic            ill_t [6];
    int              n;
    int              lat;
`ifdef ALU_SEQ_MULDIV_EN
    n = 6;
    sel_t = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hE, 4'hF};
    a_t   = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'd5, 32'd5};
    b_t   = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0};
    exp_t = '{32'h0, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    lat_t = '{33, 33, 33, 33, 1, 1};
    ill_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    n = 2;
    sel_t = '{4'hC, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0};
    a_t   = '{32'h10000, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    b_t   = '{32'h10000, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_t = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    lat_t = '{1, 1, 1, 1, 1, 1};
    ill_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int k = 0; k < n; k++) begin
      issue(sel_t[k], a_t[k], b_t[k], lat);
      total++; if (lat !== lat_t[k]) $display("FAIL directed_latency op %h got %0d exp %0d", sel_t[k], lat, lat_t[k]); else pass_cnt++;
      total++; if (result !== exp_t[k]) $display("FAIL directed_result op %h got %h exp %h", sel_t[k], result, exp_t[k]); else pass_cnt++;
      total++; if (illegal !== ill_t[k]) $display("FAIL directed_illegal op %h got %b exp %b", sel_t[k], illegal, ill_t[k]); else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_random();
    logic [3:0]      sel;
    logic [XLEN-1:0] a, b;
    logic [XLEN:0]   exp;
    int              lat, elat;
    for (int k = 0; k < 40; k++) begin
      sel = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : XLEN'($urandom);
      exp  = model(sel, a, b);
      elat = model_lat(sel, b);
      issue(sel, a, b, lat);
      total++; if (lat !== elat) $display("FAIL rand_latency op %h got %0d exp %0d", sel, lat, elat); else pass_cnt++;
      total++; if (result !== exp[XLEN-1:0]) $display("FAIL rand_result op %h a %h b %h got %h exp %h", sel, a, b, result, exp[XLEN-1:0]); else pass_cnt++;
      total++; if (illegal !== exp[XLEN]) $display("FAIL rand_illegal op %h got %b exp %b", sel, illegal, exp[XLEN]); else pass_cnt++;
      total++; if (zero_flag !== (exp[XLEN-1:0] == '0)) $display("FAIL rand_zero op %h got %b exp %b", sel, zero_flag, exp[XLEN-1:0] == '0); else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      aluSel = (k % 2 == 0) ? 4'd2 : 4'($urandom_range(0, 10));
      i_1 = $urandom; i_2 = $urandom;
      in_valid = 1'b1;
      exp = model(aluSel, i_1, i_2);
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid op %0d got %b exp 1", k, out_valid); else pass_cnt++;
      total++; if (result !== exp[XLEN-1:0]) $display("FAIL b2b_result op %0d got %h exp %h", k, result, exp[XLEN-1:0]); else pass_cnt++;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready op %0d got %b exp 1", k, in_ready); else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", out_valid); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    issue(4'd2, 32'd3, 32'd4, lat);
    flush = 1'b1; in_valid = 1'b1; aluSel = 4'd2; i_1 = 32'd1; i_2 = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_done_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_done_in_ready got %b exp 1", in_ready); else pass_cnt++;
    if (MD_EN) begin
      aluSel = 4'hC; i_1 = 32'h1234; i_2 = 32'h5678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1; in_valid = 1'b1; aluSel = 4'd2; i_1 = 32'd9; i_2 = 32'd9;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_busy_in_ready got %b exp 1", in_ready); else pass_cnt++;
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) $display("FAIL flush_no_result got %0d valid cycles exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat;
    issue(4'd2, 32'd5, 32'd3, lat);
    if (MD_EN) begin
      consume();
      aluSel = 4'hD; i_1 = 32'hFFFF_FFFF; i_2 = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (result !== '0) $display("FAIL areset_result got %h exp 0", result); else pass_cnt++;
    total++; if (zero_flag !== 1'b1) $display("FAIL areset_zero got %b exp 1", zero_flag); else pass_cnt++;
    total++; if (illegal !== 1'b0) $display("FAIL areset_illegal got %b exp 0", illegal); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    total++; if (out_valid !== 1'b0) $display("FAIL areset_no_result got %b exp 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sra_hold();
    test_muldiv_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the pipeline's combinational ALU. It executes single-cycle RV32I-style ops plus iterative unsigned multiply/divide behind a valid/ready handshake, and sits in the EX stage between operand forwarding and the EX/MEM register. Width is parametrised, and the execute stage can stall on multi-cycle ops or flush them.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥ 4.
- `CNT_W`, default `$clog2(XLEN)+1`: iteration counter width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous abort of any in-flight op.
- `in_valid` input 1: operands and op presented.
- `in_ready` output 1: unit can accept.
- `i_1` input `XLEN`: operand A.
- `i_2` input `XLEN`: operand B.
- `aluSel` input 4: op select.
- `out_valid` output 1: result valid, held until accepted.
- `out_ready` input 1: consumer takes result.
- `result` output `XLEN`: registered result.
- `zero_flag` output 1: `result == 0`.
- `illegal` output 1: `aluSel` was an unused encoding.

## Operation
- Op encodings (legacy codes unchanged):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is `i_2[$clog2(XLEN)-1:0]`.
  - 1000 SLT (signed), 1001 PASS_B, 1010 SLTU.
  - 1100 MUL (low `XLEN`), 1101 MULHU (high `XLEN`), 1110 DIVU, 1111 REMU.
  - 1011 is illegal: result 0, `illegal`=1, latency 1.
- ADD/SUB wrap modulo 2^`XLEN`. SLT/SLTU produce 1 or 0 zero-extended.
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: iterating; `in_ready`=0.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→DONE on accept of a single-cycle op, illegal op, or DIVU/REMU with `i_2`=0.
  - IDLE→BUSY on accept of MUL/MULHU/DIVU/REMU; counter loads `XLEN`.
  - BUSY decrements the counter each cycle, performing one shift-add (mul) or one restoring shift-subtract (div) step. At count 0 → DONE.
  - DONE→IDLE when `out_ready`=1 and `in_valid`=0.
  - DONE→DONE/BUSY on same-cycle accept: `in_ready`=1 in DONE when `out_ready`=1, giving back-to-back throughput.
- Divide by zero (RISC-V semantics): DIVU = all ones, REMU = `i_1`.
- `result`, `zero_flag` and `illegal` are registered and stable while `out_valid`=1 and `out_ready`=0.
- `flush` has priority over everything. Next state is IDLE, `out_valid` drops, and a same-cycle `in_valid` is dropped (not accepted).
- Operands are captured at accept. Input changes during BUSY have no effect.

## Timing
- Reset values: FSM IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero_flag`=1, `illegal`=0, counter 0.
- An async reset mid-BUSY aborts the op. Outputs return to reset values immediately.
- Single-cycle op accepted in cycle N → `out_valid` in N+1.
- MUL/MULHU/DIVU/REMU accepted in cycle N → `out_valid` in N+`XLEN`+1 (33 for `XLEN`=32).
- Divide-by-zero → `out_valid` in N+1.
- Sustained throughput is 1 op/cycle for single-cycle ops with `out_ready` held high.
- `in_ready` is a combinational function of state and `out_ready` only. There is no path from `in_valid`.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: ops 1100–1111 are implemented as described. The BUSY state and counter exist.
- `ALU_SEQ_MULDIV_EN` undefined: 1100–1111 are treated as illegal (result 0, `illegal`=1, latency 1). The BUSY state, counter and mul/div datapath are removed, and `in_ready` depends only on DONE/`out_ready`.

## Structure
- Package `alu_pkg` holds:
  - `aluSel` encoding localparams (`ALU_AND` … `ALU_REMU`);
  - FSM state typedef `alu_state_t` (IDLE, BUSY, DONE);
  - a function returning whether an op is multi-cycle.
- Sub-module `alu_muldiv_iter` holds the iterative unsigned multiply/divide datapath: accumulator, partial-remainder and counter registers, with start/done handshake. It is instantiated only under `ALU_SEQ_MULDIV_EN`.
- Top level holds the FSM, single-cycle datapath, output registers and flush logic.

## Test plan
- Reset deasserted, then ADD `i_1`=0xFFFFFFFF, `i_2`=1 accepted in cycle N → cycle N+1: `result`=0, `zero_flag`=1, `out_valid`=1.
- SRA `i_1`=0x80000000, `i_2`=0x1F with `out_ready` low for 3 cycles → `result`=0xFFFFFFFF held stable; `in_ready`=0 until `out_ready` rises.
- MUL 0x10000 × 0x10000 → `result`=0 at N+33; MULHU same operands → `result`=1 at N+33.
- DIVU 100/7 → 14 and REMU 100/7 → 2 at N+33. DIVU 5/0 → 0xFFFFFFFF at N+1; REMU 5/0 → 5 at N+1.
- `flush` in BUSY cycle N+10 with a new `in_valid` in the same cycle → `out_valid` never asserts, the new op is not accepted, and `in_ready`=1 at N+11. A `rst_n` pulse mid-BUSY gives reset values immediately.
- Build without `ALU_SEQ_MULDIV_EN`: MUL and `aluSel`=1011 → `illegal`=1, `result`=0 at N+1. Back-to-back ADDs with `out_ready`=1 give one result per cycle.
